// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM state, transfer-size and requester-ID encodings
package mem_bus_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} arb_state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester, stall and downstream bus signals of the arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;
  logic              flush;
  logic              if_stall_o;
  logic              mem_stall_o;
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, flush,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_data_ok, data_rdata, data_data_ok, if_stall_o, mem_stall_o,
           bus_req, bus_wr, bus_size, bus_addr, bus_wdata
  );
  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, flush,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_data_ok, data_rdata, data_data_ok, if_stall_o, mem_stall_o,
           bus_req, bus_wr, bus_size, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_grant_sel.sv
// arb_grant_sel: picks fetch or data requester; ARB_ROUND_ROBIN_EN alternates on contention
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic inst_req_i,
  input  logic data_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant_i,
`endif
  output logic grant_o,
  output logic valid_o
);
  assign valid_o = inst_req_i || data_req_i;
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_o = (inst_req_i && data_req_i) ? (last_grant_i == ARB_ID_DATA ? ARB_ID_INST : ARB_ID_DATA)
                 : data_req_i ? ARB_ID_DATA : ARB_ID_INST;
`else
  assign grant_o = data_req_i ? ARB_ID_DATA : ARB_ID_INST;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one-outstanding IF/MEM bus arbiter; define ARB_ROUND_ROBIN_EN for round-robin grant
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave m
);
  arb_state_t state_q, state_d;
  logic cancel_q, cancel_d;
  logic wr_q, wr_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic gnt, gnt_vld, take, gnt_d, i_fin, d_fin, i_ok;
  assign take  = state_q == IDLE && gnt_vld;
  assign gnt_d = gnt == ARB_ID_DATA;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  assign last_grant_d = take ? gnt : last_grant_q;
  always_ff @(posedge clk)
    last_grant_q <= rst ? ARB_ID_INST : last_grant_d;
  arb_grant_sel u_sel (
    .inst_req_i(m.inst_req), .data_req_i(m.data_req), .last_grant_i(last_grant_q),
    .grant_o(gnt), .valid_o(gnt_vld)
  );
`else
  arb_grant_sel u_sel (
    .inst_req_i(m.inst_req), .data_req_i(m.data_req), .grant_o(gnt), .valid_o(gnt_vld)
  );
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           state_d = !gnt_vld ? IDLE : gnt_d ? D_ADDR : I_ADDR;
      I_ADDR:         state_d = m.bus_addr_ok ? I_DATA : I_ADDR;
      D_ADDR:         state_d = m.bus_addr_ok ? D_DATA : D_ADDR;
      I_DATA, D_DATA: state_d = m.bus_data_ok ? IDLE : state_q;
      default:        state_d = IDLE;
    endcase
  end
  assign i_fin = state_q == I_DATA && m.bus_data_ok;
  assign d_fin = state_q == D_DATA && m.bus_data_ok;
  // a flushed fetch still runs to completion on the bus; only its delivery is dropped
  assign cancel_d = i_fin ? 1'b0 : cancel_q || (m.flush && (state_q == I_ADDR || state_q == I_DATA));
  assign wr_d     = take ? gnt_d && m.data_wr : wr_q;
  assign size_d   = take ? (gnt_d ? m.data_size : SIZE_WORD) : size_q;
  assign addr_d   = take ? (gnt_d ? m.data_addr : m.inst_addr) : addr_q;
  assign wdata_d  = take ? (gnt_d ? m.data_wdata : '0) : wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
  assign i_ok           = i_fin && !cancel_q && !m.flush;
  assign m.inst_data_ok = i_ok;
  assign m.data_data_ok = d_fin;
  assign m.inst_rdata   = i_ok ? m.bus_rdata : '0;
  assign m.data_rdata   = d_fin ? m.bus_rdata : '0;
  assign m.if_stall_o   = m.inst_req && !i_ok;
  assign m.mem_stall_o  = m.data_req && !d_fin;
  assign m.bus_req      = state_q == I_ADDR || state_q == D_ADDR;
  assign m.bus_wr       = wr_q;
  assign m.bus_size     = size_q;
  assign m.bus_addr     = addr_q;
  assign m.bus_wdata    = wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus randomized transactions against a transaction-level arbiter model
module tb_mem_bus_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errs = 0;
  bit last_data = 1'b0;
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .m(bif));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " bus_req"}, 64'(bif.bus_req), 64'd0);
    chk({tag, " inst_ok"}, 64'(bif.inst_data_ok), 64'd0);
    chk({tag, " data_ok"}, 64'(bif.data_data_ok), 64'd0);
    chk({tag, " inst_rdata"}, 64'(bif.inst_rdata), 64'd0);
    chk({tag, " data_rdata"}, 64'(bif.data_rdata), 64'd0);
  endtask

  // Serve whichever requester the arbitration rule picks, starting in an IDLE cycle.
  // fl_at is the cycle offset (0 = the IDLE cycle) at which flush pulses, -1 for none.
  task automatic serve(input int a_dly, input int d_dly, input int fl_at, input logic [31:0] rd);
    bit win_d, canceled, exp_iok, exp_dok, exp_breq;
    logic [31:0] e_addr, e_wdata;
    logic e_wr;
    logic [1:0] e_size;
    int last;
    win_d = bif.data_req && !(bif.inst_req && RR && last_data);
    e_addr  = win_d ? bif.data_addr : bif.inst_addr;
    e_wdata = bif.data_wdata;
    e_wr    = win_d ? bif.data_wr : 1'b0;
    e_size  = win_d ? bif.data_size : 2'd2;
    last = a_dly + d_dly + 2;
    canceled = !win_d && fl_at >= 1 && fl_at <= last;
    for (int k = 0; k <= last; k++) begin
      bif.flush = (k == fl_at);
      bif.bus_addr_ok = (k == a_dly + 1);
      bif.bus_data_ok = (k == last) ? 1'b1 : (k <= a_dly + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.bus_rdata = (k == last) ? rd : $urandom;
      if (k == 1) begin
        if (win_d) begin
          bif.data_addr = $urandom;
          bif.data_wdata = $urandom;
          bif.data_wr = 1'($urandom_range(0, 1));
          bif.data_size = 2'($urandom_range(0, 2));
        end else bif.inst_addr = $urandom;
      end
      #1;
      exp_breq = k >= 1 && k <= a_dly + 1;
      exp_iok = k == last && !win_d && !canceled;
      exp_dok = k == last && win_d;
      chk("bus_req", 64'(bif.bus_req), 64'(exp_breq));
      if (exp_breq) begin
        chk("bus_addr", 64'(bif.bus_addr), 64'(e_addr));
        chk("bus_wr", 64'(bif.bus_wr), 64'(e_wr));
        chk("bus_size", 64'(bif.bus_size), 64'(e_size));
        if (win_d) chk("bus_wdata", 64'(bif.bus_wdata), 64'(e_wdata));
      end
      chk("inst_data_ok", 64'(bif.inst_data_ok), 64'(exp_iok));
      chk("data_data_ok", 64'(bif.data_data_ok), 64'(exp_dok));
      chk("inst_rdata", 64'(bif.inst_rdata), exp_iok ? 64'(rd) : 64'd0);
      chk("data_rdata", 64'(bif.data_rdata), exp_dok ? 64'(rd) : 64'd0);
      chk("if_stall", 64'(bif.if_stall_o), 64'(bif.inst_req && !exp_iok));
      chk("mem_stall", 64'(bif.mem_stall_o), 64'(bif.data_req && !exp_dok));
      tick();
    end
    if (win_d) bif.data_req = 1'b0;
    else bif.inst_req = 1'b0;
    bif.flush = 1'b0;
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    last_data = win_d;
  endtask

  task automatic set_inst(input logic [31:0] a);
    bif.inst_req = 1'b1;
    bif.inst_addr = a;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bif.data_req = 1'b1;
    bif.data_wr = wr;
    bif.data_size = sz;
    bif.data_addr = a;
    bif.data_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    bif.inst_req = 0; bif.inst_addr = 0; bif.data_req = 0; bif.data_wr = 0;
    bif.data_size = 0; bif.data_addr = 0; bif.data_wdata = 0; bif.flush = 0;
    bif.bus_addr_ok = 0; bif.bus_data_ok = 0; bif.bus_rdata = 0;
    tick();
    tick();
    #1;
    chk_quiet("reset");
    chk("reset bus_addr", 64'(bif.bus_addr), 64'd0);
    chk("reset bus_wr", 64'(bif.bus_wr), 64'd0);
    chk("reset bus_size", 64'(bif.bus_size), 64'd0);
    chk("reset bus_wdata", 64'(bif.bus_wdata), 64'd0);
    chk("reset if_stall", 64'(bif.if_stall_o), 64'd0);
    chk("reset mem_stall", 64'(bif.mem_stall_o), 64'd0);
    rst = 1'b0;
    tick();
    // single fetch: addr_ok at N+1, data_ok at N+3
    set_inst(32'hBFC00000);
    serve(0, 1, -1, 32'h24080001);
    // simultaneous load and fetch
    set_inst(32'hBFC00004);
    set_data(1'b0, 2'd2, 32'h80000010, 32'h0);
    serve(0, 0, -1, 32'h11112222);
    serve(0, 0, -1, 32'h33334444);
    // contention right after a data grant
    set_data(1'b0, 2'd1, 32'h80000014, 32'h0);
    serve(0, 0, -1, 32'h00005555);
    set_inst(32'hBFC00008);
    set_data(1'b0, 2'd0, 32'h80000018, 32'h0);
    serve(1, 0, -1, 32'h66667777);
    serve(0, 1, -1, 32'h8888AAAA);
    // store word
    set_data(1'b1, 2'd2, 32'h80000020, 32'hDEADBEEF);
    serve(0, 0, -1, 32'h0);
    // long address stall
    set_inst(32'hBFC0000C);
    serve(5, 0, -1, 32'h0BADF00D);
    // flush in I_DATA, then a clean refetch
    set_inst(32'hBFC00010);
    serve(0, 2, 3, 32'hCAFEBABE);
    chk_quiet("post-flush idle");
    set_inst(32'h80000180);
    serve(0, 0, -1, 32'h12345678);
    // reset during D_DATA
    set_data(1'b0, 2'd2, 32'h80000030, 32'h0);
    tick();
    bif.bus_addr_ok = 1'b1;
    tick();
    bif.bus_addr_ok = 1'b0;
    rst = 1'b1;
    bif.data_req = 1'b0;
    tick();
    rst = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'hFFFFFFFF;
    #1;
    chk_quiet("after rst");
    chk("after rst bus_addr", 64'(bif.bus_addr), 64'd0);
    chk("after rst bus_size", 64'(bif.bus_size), 64'd0);
    chk("after rst mem_stall", 64'(bif.mem_stall_o), 64'd0);
    bif.bus_data_ok = 1'b0;
    last_data = 1'b0;
    tick();
    set_inst(32'hBFC00100);
    serve(0, 0, -1, 32'h0F0F0F0F);
    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int a, d, f;
      if (!bif.inst_req && $urandom_range(0, 1)) set_inst($urandom);
      if (!bif.data_req && $urandom_range(0, 1))
        set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      if (!bif.inst_req && !bif.data_req) begin
        bif.flush = 1'($urandom_range(0, 1));
        #1;
        chk_quiet("idle");
        tick();
        bif.flush = 1'b0;
        continue;
      end
      a = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, a + d + 2) : -1;
      serve(a, d, f, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
